bcd_display_mux: RTL and testbench
==================================

# bcd_display_mux

Two-digit multiplexed seven-segment display driver that consumes the BCD outputs (`ones`, `tens`) and terminal-count flag (`tc`) of the timer's cascaded mod-10/mod-6 counters. It scans one digit at a time and drives shared segment lines plus a one-hot digit select. It also blanks the leading zero, shows a dash for non-BCD codes, and blinks the whole display while `tc` is asserted. It sits between the counter chain and the board's display pins.

## Interface

Parameters:
- `REFRESH_DIV`, default 4: clock cycles each digit is held; legal range ≥ 2.
- `BLINK_SCANS`, default 8: full scans per blink half-period; legal range ≥ 1.

Ports:
- `clock`  input  1  rising-edge system clock
- `clrn`  input  1  reset, synchronous, active-low
- `enable`  input  1  display on; low forces blank and idle
- `ones`  input  4  BCD units digit from counter chain
- `tens`  input  4  BCD tens digit from counter chain
- `tc`  input  1  terminal count from counter chain, level
- `seg`  output  7  segments, active-high; seg[0]=a … seg[6]=g
- `an`  output  2  digit select, one-hot active-high; an[0]=ones, an[1]=tens; 00 = dark
- `scan_done`  output  1  one-cycle pulse at start of each new scan

## Operation

- All outputs are registers. On any edge with `clrn`=0:
  - state=IDLE, div=0, snapshot=0, blink count=0, phase=visible.
  - `seg`=0, `an`=00, `scan_done`=0.
- States are IDLE, ONES and TENS. Transitions:
  - IDLE→ONES: first edge with `enable`=1. `ones`/`tens` are captured into the snapshot, div=0, phase=visible, blink count=0.
  - ONES→TENS: edge where div=REFRESH_DIV-1. div returns to 0.
  - TENS→ONES: edge where div=REFRESH_DIV-1. This is the scan boundary:
    - snapshot recaptured;
    - `scan_done`=1 for this cycle only;
    - blink update (below).
  - Any state→IDLE: edge with `enable`=0. Outputs go to 0/00, and div, blink count and phase are reset.
- Otherwise div increments by 1 per edge while in ONES or TENS.
- Digit decode, snapshot value v:
  - v = 0..9: a..g codes 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex, bit0=a).
  - v = 10..15: dash, 0x40 (g only).
- Output rules:
  - ONES slot: `an`=01, `seg`=decode(ones snapshot).
  - TENS slot: `an`=10, `seg`=decode(tens snapshot).
  - Leading zero: if the tens snapshot is 0, the TENS slot drives `an`=00, `seg`=0. The ones digit always shows, so 00 displays as "0".
  - Blink phase=hidden: both slots drive `an`=00, `seg`=0. State and div still advance.
- Blink update at each scan boundary, using `tc` sampled that edge:
  - `tc`=0: count=0, phase=visible.
  - `tc`=1 and count=BLINK_SCANS-1: count=0, phase toggles.
  - `tc`=1 otherwise: count increments.
  - The new phase applies from this edge's ONES slot onward.
- Inputs are sampled only at snapshot points, so mid-scan changes never tear a displayed pair.

## Timing

- Latency: `an`/`seg` for the ONES slot are valid the cycle after the enabling edge, i.e. 1-cycle registered latency.
- Each slot lasts exactly REFRESH_DIV cycles; scan period is 2·REFRESH_DIV cycles.
- `scan_done` rises every 2·REFRESH_DIV cycles. The first pulse comes at the first TENS→ONES edge, not at IDLE→ONES.
- Blink half-period is BLINK_SCANS·2·REFRESH_DIV cycles. The first toggle comes BLINK_SCANS scan boundaries after `tc` is first sampled high at a boundary.
- `enable` low for one cycle restarts the scan: IDLE on that edge, then ONES on the next enabled edge.
- `clrn` overrides `enable`.
- Simultaneous `tc` rise and input change at a boundary: both the snapshot and the blink logic use the values sampled on that same edge.

## Test plan

- Reset, then enable=1 with ones=7, tens=4, REFRESH_DIV=4:
  - the next 4 cycles show an=01, seg=0x07;
  - then 4 cycles of an=10, seg=0x66;
  - then scan_done=1 for one cycle with an=01;
  - an=00 and seg=0 throughout reset.
- Leading zero and invalid codes:
  - tens=0, ones=5 → TENS slot an=00, seg=0; ONES slot seg=0x6D.
  - ones=12 → seg=0x40 in ONES slot.
- Tear-free capture: change ones 3→8 at mid-ONES slot → seg stays 0x4F until the next scan boundary, then 0x7F.
- Blink with BLINK_SCANS=2: hold tc=1 →
  - scans 1-2 visible, scans 3-4 an=00, scans 5-6 visible;
  - drop tc → visible from the next boundary onward.
- Disable mid-TENS: enable=0 for one cycle →
  - an=00, seg=0 on that edge;
  - re-enable → ONES slot with a fresh snapshot, div restarted.
- Reset mid-operation (clrn=0 for one edge during blink hidden phase) → all outputs 0, phase visible after re-enable.

Source files
------------

// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed seven-segment driver for the timer's BCD counter chain.
// Scans ones then tens, blanks a leading zero, dashes non-BCD codes, and blinks on tc.
module bcd_display_mux #(
    parameter int REFRESH_DIV = 4,
    parameter int BLINK_SCANS = 8
) (
    input  logic       clock,
    input  logic       clrn,
    input  logic       enable,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic       tc,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       scan_done
);

    localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_SCANS > 2) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SCANS - 1);

    typedef enum logic [1:0] {IDLE, ONES, TENS} state_t;

    state_t        state;
    logic [DW-1:0] div;
    logic [3:0]    snap_ones;
    logic [3:0]    snap_tens;
    logic [BW-1:0] blink_count;
    logic          hidden;
    logic [BW-1:0] next_count;
    logic          next_hidden;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    // Blink bookkeeping as it would look after a scan boundary sampling tc now.
    always_comb begin
        next_count  = blink_count;
        next_hidden = hidden;
        if (!tc) begin
            next_count  = '0;
            next_hidden = 1'b0;
        end else if (blink_count == BLINK_LAST) begin
            next_count  = '0;
            next_hidden = !hidden;
        end else begin
            next_count = blink_count + BW'(1);
        end
    end

    // Outputs are computed from the post-edge state so each slot shows from its first cycle.
    always_ff @(posedge clock) begin
        if (!clrn) begin
            state       <= IDLE;
            div         <= '0;
            snap_ones   <= '0;
            snap_tens   <= '0;
            blink_count <= '0;
            hidden      <= 1'b0;
            seg         <= '0;
            an          <= '0;
            scan_done   <= 1'b0;
        end else if (!enable) begin
            state       <= IDLE;
            div         <= '0;
            blink_count <= '0;
            hidden      <= 1'b0;
            seg         <= '0;
            an          <= '0;
            scan_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= ONES;
                    div         <= '0;
                    snap_ones   <= ones;
                    snap_tens   <= tens;
                    blink_count <= '0;
                    hidden      <= 1'b0;
                    an          <= 2'b01;
                    seg         <= decode(ones);
                    scan_done   <= 1'b0;
                end
                ONES: begin
                    scan_done <= 1'b0;
                    if (div == DIV_LAST) begin
                        state <= TENS;
                        div   <= '0;
                        if (hidden || snap_tens == 4'd0) begin
                            an  <= 2'b00;
                            seg <= '0;
                        end else begin
                            an  <= 2'b10;
                            seg <= decode(snap_tens);
                        end
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                TENS: begin
                    if (div == DIV_LAST) begin
                        state       <= ONES;
                        div         <= '0;
                        snap_ones   <= ones;
                        snap_tens   <= tens;
                        blink_count <= next_count;
                        hidden      <= next_hidden;
                        scan_done   <= 1'b1;
                        if (next_hidden) begin
                            an  <= 2'b00;
                            seg <= '0;
                        end else begin
                            an  <= 2'b01;
                            seg <= decode(ones);
                        end
                    end else begin
                        div       <= div + DW'(1);
                        scan_done <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    div       <= '0;
                    seg       <= '0;
                    an        <= '0;
                    scan_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Self-checking bench for bcd_display_mux: scan-position model compared every cycle,
// plus hand-computed literal checks along a directed scenario.
module tb_bcd_display_mux;

    localparam int R  = 4;
    localparam int BS = 2;

    logic       clock;
    logic       clrn;
    logic       enable;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       tc;
    logic [6:0] seg;
    logic [1:0] an;
    logic       scan_done;

    int assert_count = 0;
    int fail_count   = 0;
    bit check_on     = 0;

    bcd_display_mux #(.REFRESH_DIV(R), .BLINK_SCANS(BS)) dut (
        .clock(clock), .clrn(clrn), .enable(enable), .ones(ones), .tens(tens),
        .tc(tc), .seg(seg), .an(an), .scan_done(scan_done)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    logic [6:0] segtab [16];
    initial begin
        segtab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                   7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    end

    // Model: k counts cycles since the display started; a scan boundary is every 2R cycles,
    // and blinking depends only on how many consecutive boundaries have seen tc high.
    bit         m_active;
    int         m_k;
    int         m_run;
    logic [3:0] m_ones, m_tens;
    logic [6:0] exp_seg;
    logic [1:0] exp_an;
    logic       exp_sd;

    always @(posedge clock) begin
        if (!clrn || !enable) begin
            m_active = 0;
            m_run    = 0;
            if (!clrn) begin
                m_ones = 0;
                m_tens = 0;
            end
            exp_seg = 0;
            exp_an  = 0;
            exp_sd  = 0;
        end else begin
            exp_sd = 0;
            if (!m_active) begin
                m_active = 1;
                m_k      = 0;
                m_run    = 0;
                m_ones   = ones;
                m_tens   = tens;
            end else begin
                m_k = m_k + 1;
                if (m_k % (2 * R) == 0) begin
                    m_ones = ones;
                    m_tens = tens;
                    m_run  = tc ? m_run + 1 : 0;
                    exp_sd = 1;
                end
            end
            if (((m_run / BS) % 2) == 1) begin
                exp_an  = 2'b00;
                exp_seg = 0;
            end else if (((m_k / R) % 2) == 0) begin
                exp_an  = 2'b01;
                exp_seg = segtab[m_ones];
            end else if (m_tens == 0) begin
                exp_an  = 2'b00;
                exp_seg = 0;
            end else begin
                exp_an  = 2'b10;
                exp_seg = segtab[m_tens];
            end
        end
    end

    always @(negedge clock) begin
        if (check_on) begin
            assert_count++;
            if (seg !== exp_seg || an !== exp_an || scan_done !== exp_sd) begin
                fail_count++;
                $display("[TB] FAIL model_cmp t=%0t: got an=%b seg=%h sd=%b, expected an=%b seg=%h sd=%b",
                         $time, an, seg, scan_done, exp_an, exp_seg, exp_sd);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [1:0] e_an,
                               input logic [6:0] e_seg, input logic e_sd);
        assert_count++;
        if (an !== e_an || seg !== e_seg || scan_done !== e_sd) begin
            fail_count++;
            $display("[TB] FAIL %s: got an=%b seg=%h sd=%b, expected an=%b seg=%h sd=%b",
                     name, an, seg, scan_done, e_an, e_seg, e_sd);
        end
    endtask

    // Advances to the negedge just after the next scan boundary, bounded.
    task automatic waitScan();
        int n = 0;
        @(negedge clock);
        while (scan_done !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (scan_done !== 1'b1) begin
            assert_count++;
            fail_count++;
            $display("[TB] FAIL scan_timeout: got sd=%b, expected sd=1 within 100 cycles", scan_done);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] o, input logic [3:0] t, input logic c);
        ones = o;
        tens = t;
        tc   = c;
    endtask

    initial begin
        clrn = 0; enable = 0;
        applyStimulus(4'd0, 4'd0, 1'b0);
        repeat (3) @(negedge clock);
        check_on = 1;
        checkOutput("reset", 2'b00, 7'h00, 1'b0);

        applyStimulus(4'd7, 4'd4, 1'b0);
        clrn = 1; enable = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("first_ones", 2'b01, 7'h07, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("first_tens", 2'b10, 7'h66, 1'b0);
        end
        @(negedge clock);
        checkOutput("first_scan_done", 2'b01, 7'h07, 1'b1);

        applyStimulus(4'd5, 4'd0, 1'b0);
        waitScan();
        checkOutput("lz_ones", 2'b01, 7'h6D, 1'b1);
        repeat (4) @(negedge clock);
        checkOutput("lz_tens", 2'b00, 7'h00, 1'b0);

        applyStimulus(4'd12, 4'd3, 1'b0);
        waitScan();
        checkOutput("dash", 2'b01, 7'h40, 1'b1);

        applyStimulus(4'd3, 4'd1, 1'b0);
        waitScan();
        checkOutput("tear_before", 2'b01, 7'h4F, 1'b1);
        repeat (2) @(negedge clock);
        ones = 4'd8;
        @(negedge clock);
        checkOutput("tear_hold", 2'b01, 7'h4F, 1'b0);
        waitScan();
        checkOutput("tear_after", 2'b01, 7'h7F, 1'b1);

        tc = 1;
        waitScan();
        checkOutput("blink_scan2", 2'b01, 7'h7F, 1'b1);
        waitScan();
        checkOutput("blink_scan3", 2'b00, 7'h00, 1'b1);
        waitScan();
        checkOutput("blink_scan4", 2'b00, 7'h00, 1'b1);
        waitScan();
        checkOutput("blink_scan5", 2'b01, 7'h7F, 1'b1);
        waitScan();
        waitScan();
        checkOutput("blink_hidden_again", 2'b00, 7'h00, 1'b1);
        repeat (5) @(negedge clock);
        checkOutput("blink_hidden_tens", 2'b00, 7'h00, 1'b0);

        clrn = 0;
        @(negedge clock);
        checkOutput("reset_mid", 2'b00, 7'h00, 1'b0);
        clrn = 1;
        @(negedge clock);
        checkOutput("reset_visible", 2'b01, 7'h7F, 1'b0);

        waitScan();
        waitScan();
        checkOutput("blink_pre_drop", 2'b00, 7'h00, 1'b1);
        tc = 0;
        waitScan();
        checkOutput("blink_drop", 2'b01, 7'h7F, 1'b1);

        waitScan();
        repeat (5) @(negedge clock);
        checkOutput("dis_tens", 2'b10, 7'h06, 1'b0);
        enable = 0;
        applyStimulus(4'd2, 4'd9, 1'b0);
        @(negedge clock);
        checkOutput("dis_blank", 2'b00, 7'h00, 1'b0);
        enable = 1;
        @(negedge clock);
        checkOutput("reen_ones", 2'b01, 7'h5B, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("restart_ones", 2'b01, 7'h5B, 1'b0);
        @(negedge clock);
        checkOutput("restart_tens", 2'b10, 7'h6F, 1'b0);

        enable = 0;
        repeat (3) @(negedge clock);
        checkOutput("final_off", 2'b00, 7'h00, 1'b0);

        check_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
